// File: rtl/seq_pkg.sv
// Shared types for the serial pattern source and its detector benches.
// Holds the FSM state encoding and the canonical 01010 test pattern.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [4:0] PAT_01010 = 5'b01010;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/stream bundle of seq_pattern_tx.
// master drives start/abort/pattern/len/reps; slave returns xout/xvalid/busy/done.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int RPT_W = 4
);
  localparam int LW = $clog2(WIDTH + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [RPT_W-1:0] reps;
  logic             xout;
  logic             xvalid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps,
    input  xout, xvalid, busy, done
  );

  modport slave (
    input  start, abort, pattern, len, reps,
    output xout, xvalid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx_piso.sv
// piso_shift: WIDTH-bit parallel-load, MSB-first shift register.
// Ports: clk, rst (async low), load_i, shift_i, din_i, msb_o.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: MSB-first bursts with repeats and gaps.
// Ports: clk, rst (async low), bus (seq_pattern_tx_if.slave).
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_tx_if.slave  bus
);

  localparam int LW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_GAP   = GAP;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [RPT_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             xout_q, xout_d;
  logic             xvalid_q, xvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ld, sh, msb;
  logic [WIDTH-1:0] ld_data;
  logic [LW-1:0]    len_c;
  logic [RPT_W-1:0] rep_c;
  logic [WIDTH-1:0] aligned;

  assign len_c = (bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
  assign rep_c = (bus.reps == '0) ? RPT_W'(1) : bus.reps;
  // Left-justify so pattern[len-1] sits in the shifter MSB.
  assign aligned = bus.pattern << (LW'(WIDTH) - len_c);

  // Shifter holds only the bits still to come; the current bit
  // lives in xout_q so the output is a true flop.
  piso_shift #(.WIDTH(WIDTH)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .shift_i (sh),
    .din_i   (ld_data),
    .msb_o   (msb)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    xout_d   = 1'b0;
    xvalid_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ld       = 1'b0;
    sh       = 1'b0;
    ld_data  = pat_q << 1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          pat_d = aligned;
          len_d = len_c;
          rep_d = rep_c;
          if (len_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_SHIFT;
            busy_d   = 1'b1;
            xout_d   = aligned[WIDTH-1];
            xvalid_d = 1'b1;
            cnt_d    = len_c;
            ld       = 1'b1;
            ld_data  = aligned << 1;
          end
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q > LW'(1)) begin
          xout_d   = msb;
          xvalid_d = 1'b1;
          sh       = 1'b1;
          cnt_d    = cnt_q - LW'(1);
        end else if (rep_q > RPT_W'(1)) begin
          rep_d = rep_q - RPT_W'(1);
          if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end else begin
            xout_d   = pat_q[WIDTH-1];
            xvalid_d = 1'b1;
            ld       = 1'b1;
            cnt_d    = len_q;
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (gap_q == '0) begin
          state_d  = S_SHIFT;
          xout_d   = pat_q[WIDTH-1];
          xvalid_d = 1'b1;
          ld       = 1'b1;
          cnt_d    = len_q;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      xout_q   <= 1'b0;
      xvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      xout_q   <= xout_d;
      xvalid_q <= xvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.xout   = xout_q;
  assign bus.xvalid = xvalid_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: a no-gap instance and a
// GAP_CYCLES=2 instance, with a small 01010 detector model.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  seq_pattern_tx_if #(.WIDTH(8), .RPT_W(4)) b0 ();
  seq_pattern_tx_if #(.WIDTH(8), .RPT_W(4)) b2 ();

  seq_pattern_tx #(.WIDTH(8), .RPT_W(4), .GAP_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  seq_pattern_tx #(.WIDTH(8), .RPT_W(4), .GAP_CYCLES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start0(input logic [7:0] p,
                        input logic [3:0] l,
                        input logic [3:0] r);
    b0.pattern = p;
    b0.len     = l;
    b0.reps    = r;
    b0.start   = 1'b1;
    tick();
    b0.start   = 1'b0;
  endtask

  initial begin
    logic [4:0] p5;
    logic [7:0] a5;
    logic [7:0] c3;
    logic [4:0] win;
    int         seen;
    int         hits;
    int         nval;
    int         pos;

    nvec = 0;
    nerr = 0;
    p5 = PAT_01010;
    a5 = 8'hA5;
    c3 = 8'hC3;
    b0.start = 0; b0.abort = 0; b0.pattern = '0;
    b0.len = '0; b0.reps = '0;
    b2.start = 0; b2.abort = 0; b2.pattern = '0;
    b2.len = '0; b2.reps = '0;

    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_xout", b0.xout, 0);
    chk("rst_xvalid", b0.xvalid, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_xvalid2", b2.xvalid, 0);
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // single 01010 burst; start while busy must be ignored
    start0({3'b0, p5}, 4'd5, 4'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t1_bit", b0.xout, p5[4-i]);
      chk("t1_valid", b0.xvalid, 1);
      chk("t1_busy", b0.busy, 1);
      if (i == 2) begin
        b0.start = 1'b1;
        b0.pattern = 8'hFF;
      end
      if (i == 3) b0.start = 1'b0;
      tick();
    end
    chk("t1_done", b0.done, 1);
    chk("t1_busy_end", b0.busy, 0);
    chk("t1_valid_end", b0.xvalid, 0);
    tick();
    chk("t1_done_clr", b0.done, 0);

    // two back-to-back reps into a 01010 detector model
    start0({3'b0, p5}, 4'd5, 4'd2);
    win = '0; seen = 0; hits = 0;
    for (int i = 0; i < 10; i++) begin
      chk("t2_valid", b0.xvalid, 1);
      chk("t2_bit", b0.xout, p5[4-(i%5)]);
      if (b0.xvalid) begin
        win = {win[3:0], b0.xout};
        seen++;
        if (seen >= 5 && win == PAT_01010) hits++;
      end
      tick();
    end
    chk("t2_done", b0.done, 1);
    chk("t2_hits", hits, 2);
    tick();

    // A5 x3 with 2-cycle gaps
    b2.pattern = 8'hA5;
    b2.len = 4'd8;
    b2.reps = 4'd3;
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    nval = 0;
    for (int c = 0; c < 28; c++) begin
      pos = c % 10;
      chk("t3_busy", b2.busy, 1);
      if (pos < 8) begin
        chk("t3_valid", b2.xvalid, 1);
        chk("t3_bit", b2.xout, a5[7-pos]);
      end else begin
        chk("t3_gapv", b2.xvalid, 0);
        chk("t3_gapx", b2.xout, 0);
      end
      if (b2.xvalid) nval++;
      tick();
    end
    chk("t3_done", b2.done, 1);
    chk("t3_nvalid", nval, 24);
    tick();

    // abort on the 3rd bit
    start0({3'b0, p5}, 4'd5, 4'd1);
    tick();
    tick();
    chk("t4_bit3", b0.xout, p5[2]);
    chk("t4_valid3", b0.xvalid, 1);
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    chk("t4_valid", b0.xvalid, 0);
    chk("t4_busy", b0.busy, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t4_nodone", b0.done, 0);
      tick();
    end
    b0.abort = 1'b1;
    start0({3'b0, p5}, 4'd5, 4'd1);
    b0.abort = 1'b0;
    chk("t4_ab_busy", b0.busy, 0);
    chk("t4_ab_valid", b0.xvalid, 0);
    chk("t4_ab_done", b0.done, 0);
    tick();

    // len = 0
    start0(8'hFF, 4'd0, 4'd1);
    chk("t5_done", b0.done, 1);
    chk("t5_busy", b0.busy, 0);
    chk("t5_valid", b0.xvalid, 0);
    tick();
    chk("t5_done_clr", b0.done, 0);
    chk("t5_valid2", b0.xvalid, 0);

    // reps = 0 behaves as reps = 1
    start0({3'b0, p5}, 4'd5, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_r0_bit", b0.xout, p5[4-i]);
      chk("t5_r0_valid", b0.xvalid, 1);
      tick();
    end
    chk("t5_r0_done", b0.done, 1);
    tick();

    // len above WIDTH clamps to 8
    start0(8'hC3, 4'd12, 4'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t5_cl_bit", b0.xout, c3[7-i]);
      chk("t5_cl_valid", b0.xvalid, 1);
      tick();
    end
    chk("t5_cl_done", b0.done, 1);
    tick();

    // async reset mid-burst, then a clean burst
    start0(8'hFF, 4'd8, 4'd1);
    tick();
    chk("t6_pre", b0.xvalid, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_xout", b0.xout, 0);
    chk("t6_xvalid", b0.xvalid, 0);
    chk("t6_busy", b0.busy, 0);
    chk("t6_done", b0.done, 0);
    #1 rst = 1'b1;
    tick();
    start0({3'b0, p5}, 4'd5, 4'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t6_bit", b0.xout, p5[4-i]);
      chk("t6_valid", b0.xvalid, 1);
      tick();
    end
    chk("t6_done_end", b0.done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
